// File: rtl/id_stage.sv
// id_stage: decode / operand-fetch stage feeding the execute ALU.
// Holds the 32x32 register file (R0 hard-wired to zero), decodes one
// instruction per cycle over a valid/ready handshake and presents
// InputA/InputB/ALUop/OutRd/OutWrEn from a single registered stage.
// Optional feature: define WB_BYPASS_EN to forward a same-cycle writeback
// into the operands being loaded; otherwise operands see the pre-edge value.
module id_stage #(
   parameter int NREGS = 32,
   parameter int IMMW  = 14
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        InValid,
   output logic        InReady,
   input  logic [31:0] Instr,
   input  logic        WbEn,
   input  logic [4:0]  WbAddr,
   input  logic [31:0] WbData,
   output logic        OutValid,
   input  logic        OutReady,
   output logic [31:0] InputA,
   output logic [31:0] InputB,
   output logic [2:0]  ALUop,
   output logic [4:0]  OutRd,
   output logic        OutWrEn
);

   logic [31:0] rf_q [NREGS];

   logic [2:0]  op;
   logic [4:0]  rd, rs, rt;
   logic [31:0] imm_ext;
   logic [31:0] rs_val, rt_val;

   logic [31:0] a_d, b_d, a_q, b_q;
   logic [2:0]  op_d, op_q;
   logic [4:0]  rd_d, rd_q;
   logic        we_d, we_q;
   logic        valid_q;
   logic        load;

   assign op      = Instr[31:29];
   assign rd      = Instr[28:24];
   assign rs      = Instr[23:19];
   assign rt      = Instr[18:14];
   assign imm_ext = {{(32-IMMW){Instr[IMMW-1]}}, Instr[IMMW-1:0]};

   assign InReady = !valid_q || OutReady;
   assign load    = InValid && InReady;

   // Register-file write port; writes to R0 are dropped so it stays zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
      end else if (WbEn && (WbAddr != 5'd0)) begin
         rf_q[WbAddr] <= WbData;
      end
   end

   // Combinational read ports, with optional same-cycle writeback forwarding.
   always_comb begin
      rs_val = (rs == 5'd0) ? 32'd0 : rf_q[rs];
      rt_val = (rt == 5'd0) ? 32'd0 : rf_q[rt];
`ifdef WB_BYPASS_EN
      if (WbEn && (WbAddr != 5'd0) && (WbAddr == rs)) rs_val = WbData;
      if (WbEn && (WbAddr != 5'd0) && (WbAddr == rt)) rt_val = WbData;
`else
`endif
   end

   // Instruction decode into next-state values for the output stage.
   always_comb begin
      a_d  = 32'd0;
      b_d  = 32'd0;
      op_d = op;
      rd_d = 5'd0;
      we_d = 1'b0;
      case (op)
         3'b000, 3'b001: begin
            // NOOP: everything except ALUop stays zero.
         end
         3'b110, 3'b111: begin
            a_d  = rs_val;
            b_d  = imm_ext;
            rd_d = rd;
            we_d = (rd != 5'd0);
         end
         default: begin
            a_d  = rs_val;
            b_d  = rt_val;
            rd_d = rd;
            we_d = (rd != 5'd0);
         end
      endcase
   end

   // Output stage: capture on load, drop valid when consumed without a refill.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         rd_q    <= '0;
         we_q    <= 1'b0;
      end else if (load) begin
         valid_q <= 1'b1;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         rd_q    <= rd_d;
         we_q    <= we_d;
      end else if (OutReady) begin
         valid_q <= 1'b0;
      end
   end

   assign OutValid = valid_q;
   assign InputA   = a_q;
   assign InputB   = b_q;
   assign ALUop    = op_q;
   assign OutRd    = rd_q;
   assign OutWrEn  = we_q;

endmodule

// File: tb/tb_id_stage.sv
// Testbench for id_stage: scoreboard with a behavioural decode model.
module tb_id_stage;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  op;
      logic [4:0]  rd;
      logic        we;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        InValid = 1'b0;
   logic        InReady;
   logic [31:0] Instr = '0;
   logic        WbEn = 1'b0;
   logic [4:0]  WbAddr = '0;
   logic [31:0] WbData = '0;
   logic        OutValid;
   logic        OutReady = 1'b1;
   logic [31:0] InputA;
   logic [31:0] InputB;
   logic [2:0]  ALUop;
   logic [4:0]  OutRd;
   logic        OutWrEn;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] mregs [32];
   exp_t        q [$];

   id_stage dut (
      .clk(clk), .rst_n(rst_n), .InValid(InValid), .InReady(InReady),
      .Instr(Instr), .WbEn(WbEn), .WbAddr(WbAddr), .WbData(WbData),
      .OutValid(OutValid), .OutReady(OutReady), .InputA(InputA),
      .InputB(InputB), .ALUop(ALUop), .OutRd(OutRd), .OutWrEn(OutWrEn)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] mk(input int op, input int rd, input int rs,
                                      input int rt, input int imm);
      logic [31:0] w;
      w[31:29] = 3'(op);
      w[28:24] = 5'(rd);
      w[23:19] = 5'(rs);
      w[18:14] = 5'(rt);
      w[13:0]  = 14'(imm);
      return w;
   endfunction

   // Value an operand read should see for register idx at load time.
   function automatic logic [31:0] rdreg(input int idx, input logic we,
                                         input logic [4:0] wa, input logic [31:0] wd);
      if (idx == 0) return 32'd0;
`ifdef WB_BYPASS_EN
      if (we && (int'(wa) == idx)) return wd;
`else
      if (we && wa == 5'd31 && wd == 32'hx) return 32'd0;
`endif
      return mregs[idx];
   endfunction

   function automatic exp_t model(input logic [31:0] ins, input logic we,
                                  input logic [4:0] wa, input logic [31:0] wd);
      exp_t e;
      int   op, rd, rs, rt, imm_s;
      logic signed [13:0] imm;
      op  = int'(ins[31:29]);
      rd  = int'(ins[28:24]);
      rs  = int'(ins[23:19]);
      rt  = int'(ins[18:14]);
      imm = ins[13:0];
      imm_s = imm;
      e = '0;
      e.op = ins[31:29];
      if (op >= 2) begin
         e.a  = rdreg(rs, we, wa, wd);
         e.b  = (op >= 6) ? 32'(imm_s) : rdreg(rt, we, wa, wd);
         e.rd = 5'(rd);
         e.we = (rd != 0);
      end
      return e;
   endfunction

   // Reference model: accepts whenever its own output slot is empty.
   initial begin
      for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
            q.delete();
         end else begin
            if (InValid && q.size() == 0) q.push_back(model(Instr, WbEn, WbAddr, WbData));
            if (WbEn && WbAddr != 5'd0) mregs[WbAddr] = WbData;
         end
      end
   end

   // Monitor: compare presented outputs against the scoreboard head.
   initial begin
      exp_t act;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            chk("InReady", {63'd0, InReady}, {63'd0, (q.size() == 0) || OutReady});
            if (q.size() != 0) begin
               act = '{a: InputA, b: InputB, op: ALUop, rd: OutRd, we: OutWrEn};
               chk("OutValid", {63'd0, OutValid}, 64'd1);
               n_tests++;
               if (act !== q[0]) begin
                  n_fail++;
                  $display("FAIL outputs: got a=%h b=%h op=%h rd=%0d we=%b expected a=%h b=%h op=%h rd=%0d we=%b",
                           act.a, act.b, act.op, act.rd, act.we,
                           q[0].a, q[0].b, q[0].op, q[0].rd, q[0].we);
               end
               if (OutReady) void'(q.pop_front());
            end else begin
               chk("OutValid_idle", {63'd0, OutValid}, 64'd0);
            end
         end
      end
   end

   task automatic step(input logic iv, input logic [31:0] ins, input logic we,
                       input logic [4:0] wa, input logic [31:0] wd, input logic ordy);
      InValid  = iv;
      Instr    = ins;
      WbEn     = we;
      WbAddr   = wa;
      WbData   = wd;
      OutReady = ordy;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] held_a;
      logic [31:0] exp_byp;
      // Reset state
      #12;
      chk("rst_OutValid", {63'd0, OutValid}, 64'd0);
      chk("rst_InputA", {32'd0, InputA}, 64'd0);
      chk("rst_InReady", {63'd0, InReady}, 64'd1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      step(0, 0, 0, 0, 0, 1);

      // Write R3 then ADD rd=5 rs=3 rt=0
      step(0, 0, 1, 5'd3, 32'h10, 1);
      step(1, mk(2, 5, 3, 0, 0), 0, 0, 0, 1);
      chk("add_valid", {63'd0, OutValid}, 64'd1);
      chk("add_A", {32'd0, InputA}, 64'h10);
      chk("add_B", {32'd0, InputB}, 64'd0);
      chk("add_op", {61'd0, ALUop}, 64'd2);
      chk("add_rd", {59'd0, OutRd}, 64'd5);
      chk("add_we", {63'd0, OutWrEn}, 64'd1);

      // Immediates
      step(0, 0, 1, 5'd2, 32'd7, 1);
      step(1, mk(6, 1, 2, 0, 14'h3FFF), 0, 0, 0, 1);
      chk("addi_A", {32'd0, InputA}, 64'd7);
      chk("addi_B", {32'd0, InputB}, 64'hFFFF_FFFF);
      chk("addi_op", {61'd0, ALUop}, 64'd6);
      step(1, mk(7, 1, 2, 0, 14'h1FFF), 0, 0, 0, 1);
      chk("subi_B", {32'd0, InputB}, 64'h0000_1FFF);
      chk("subi_op", {61'd0, ALUop}, 64'd7);

      // Back-to-back then stall
      for (int i = 0; i < 4; i++) begin
         step(1, mk(2 + i, i + 1, 3, 2, 0), 0, 0, 0, 1);
         chk("b2b_valid", {63'd0, OutValid}, 64'd1);
         chk("b2b_ready", {63'd0, InReady}, 64'd1);
      end
      step(1, mk(2, 8, 2, 3, 0), 0, 0, 0, 1);
      held_a = InputA;
      for (int i = 0; i < 3; i++) begin
         step(1, mk(3, 9, 3, 2, 0), 0, 0, 0, 0);
         chk("stall_ready", {63'd0, InReady}, 64'd0);
         chk("stall_A", {32'd0, InputA}, {32'd0, held_a});
         chk("stall_op", {61'd0, ALUop}, 64'd2);
      end
      step(1, mk(3, 9, 3, 2, 0), 0, 0, 0, 1);
      chk("resume_op", {61'd0, ALUop}, 64'd3);
      chk("resume_A", {32'd0, InputA}, 64'h10);
      chk("resume_B", {32'd0, InputB}, 64'd7);
      step(0, 0, 0, 0, 0, 1);

      // Same-cycle writeback vs. decode; R0 writes
      step(0, 0, 1, 5'd4, 32'd1, 1);
      step(1, mk(2, 6, 4, 0, 0), 1, 5'd4, 32'hDEAD_BEEF, 1);
`ifdef WB_BYPASS_EN
      exp_byp = 32'hDEAD_BEEF;
`else
      exp_byp = 32'd1;
`endif
      chk("bypass_A", {32'd0, InputA}, {32'd0, exp_byp});
      step(0, 0, 1, 5'd0, 32'hFFFF_FFFF, 1);
      step(1, mk(2, 7, 0, 0, 0), 0, 0, 0, 1);
      chk("r0_A", {32'd0, InputA}, 64'd0);
      chk("r0_B", {32'd0, InputB}, 64'd0);

      // NOOP with nonzero fields; ADD to rd=0
      step(1, {3'b001, 5'd9, 5'd3, 5'd4, 14'h155}, 0, 0, 0, 1);
      chk("noop_A", {32'd0, InputA}, 64'd0);
      chk("noop_B", {32'd0, InputB}, 64'd0);
      chk("noop_we", {63'd0, OutWrEn}, 64'd0);
      chk("noop_rd", {59'd0, OutRd}, 64'd0);
      step(1, mk(2, 0, 3, 3, 0), 0, 0, 0, 1);
      chk("rd0_we", {63'd0, OutWrEn}, 64'd0);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 3) != 0,
              mk($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                 $urandom_range(0, 7), $urandom),
              $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
              $urandom_range(0, 9) < 7);
      end

      // Reset while stalled
      step(1, mk(2, 5, 3, 3, 0), 1, 5'd3, 32'h55, 1);
      step(0, 0, 0, 0, 0, 0);
      chk("prerst_valid", {63'd0, OutValid}, 64'd1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", {63'd0, OutValid}, 64'd0);
      chk("arst_A", {32'd0, InputA}, 64'd0);
      chk("arst_B", {32'd0, InputB}, 64'd0);
      chk("arst_misc", {55'd0, ALUop, OutRd, OutWrEn}, 64'd0);
      chk("arst_ready", {63'd0, InReady}, 64'd1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 1; i < 32; i++) begin
         step(1, mk(2, 1, i, i, 0), 0, 0, 0, 1);
         chk("postrst_A", {32'd0, InputA}, 64'd0);
         chk("postrst_B", {32'd0, InputB}, 64'd0);
      end
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
